// File: rtl/fpu_disp_pkg.sv
// Shared encodings for the FPU display sequencer: states, select codes,
// binary16 field positions and special-value helpers.
package fpu_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHOW_A = 2'b01,
        SHOW_B = 2'b10,
        SHOW_R = 2'b11
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_R    = 2'b11;

    localparam int         EXP_MSB      = 14;
    localparam int         EXP_LSB      = 10;
    localparam int         MAN_W        = 10;
    localparam logic [4:0] EXP_ALL_ONES = 5'h1F;

    localparam int DWELL_CYCLES_DEF = 50_000_000;
    localparam int CNT_W_DEF        = 26;

    // Operand/result triple held in the shadow registers.
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } triple_t;

    function automatic logic is_nan(input logic [15:0] w);
        return (w[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (w[MAN_W-1:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [15:0] w);
        return (w[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (w[MAN_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/fpu_display_sequencer_dwell_timer.sv
// Dwell counter: counts enabled cycles and emits a one-cycle tick on the
// cycle it sits at DWELL_CYCLES-1, wrapping to 0 on that edge.
module dwell_timer
    import fpu_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over counting; with neither asserted the count holds.
    always_comb begin
        tick  = enable && !clear && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (tick)   cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fpu_display_sequencer.sv
// Picks which binary16 word (A, B or result) feeds the hex display, captures
// triples from the FPU and flags NaN/Inf on the word being shown.
module fpu_display_sequencer
    import fpu_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [15:0] res,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic        mode_auto,
    input  logic        step_pulse,
    input  logic        freeze,
    output logic [15:0] disp_word,
    output logic [1:0]  disp_sel,
    output logic        disp_blank,
    output logic        disp_nan,
    output logic        disp_inf
);

    state_e      state_q, state_d;
    triple_t     sh_q, sh_d;
    logic        mode_q;
    logic [15:0] word_q, word_d;
    logic [1:0]  sel_q, sel_d;
    logic        blank_q, nan_q, inf_q;

    logic cap, mode_chg, tmr_en, tmr_clr, tick, advance;

    assign res_ready = !rst && !freeze;
    assign cap       = res_valid && res_ready;
    assign mode_chg  = (mode_auto != mode_q);

    // Timer only runs while a word is shown in auto mode; it is parked at 0
    // in manual mode and restarted on capture or a mode flip. Freeze holds it.
    assign tmr_en  = mode_auto && !freeze && (state_q != IDLE);
    assign tmr_clr = !freeze && (cap || mode_chg || !mode_auto);

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .enable (tmr_en),
        .clear  (tmr_clr),
        .tick   (tick)
    );

    assign advance = !freeze && (state_q != IDLE) && (mode_auto ? tick : step_pulse);

    // Next state, shadow capture and next displayed word; capture beats advance.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        if (cap) begin
            sh_d    = '{a: op_a, b: op_b, r: res};
            state_d = SHOW_R;
        end else if (advance) begin
            unique case (state_q)
                SHOW_A:  state_d = SHOW_B;
                SHOW_B:  state_d = SHOW_R;
                SHOW_R:  state_d = SHOW_A;
                default: state_d = state_q;
            endcase
        end

        word_d = '0;
        sel_d  = SEL_NONE;
        unique case (state_d)
            SHOW_A:  begin word_d = sh_d.a; sel_d = SEL_A; end
            SHOW_B:  begin word_d = sh_d.b; sel_d = SEL_B; end
            SHOW_R:  begin word_d = sh_d.r; sel_d = SEL_R; end
            default: begin word_d = '0;     sel_d = SEL_NONE; end
        endcase
    end

    // State, shadow triple and last-seen mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            mode_q  <= mode_auto;
        end
    end

    // Registered display outputs, all derived from the next-state source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            sel_q   <= SEL_NONE;
            blank_q <= 1'b1;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            sel_q   <= sel_d;
            blank_q <= (state_d == IDLE);
            nan_q   <= is_nan(word_d);
            inf_q   <= is_inf(word_d);
        end
    end

    assign disp_word  = word_q;
    assign disp_sel   = sel_q;
    assign disp_blank = blank_q;
    assign disp_nan   = nan_q;
    assign disp_inf   = inf_q;

endmodule

// File: tb/tb_fpu_display_sequencer.sv
// Bench for fpu_display_sequencer with a short dwell: directed scenarios with
// literal expectations, then randomized traffic, all checked every cycle
// against a word-index model of the display.
module tb_fpu_display_sequencer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] op_a = '0, op_b = '0, res = '0;
    logic        res_valid = 1'b0, mode_auto = 1'b0, step_pulse = 1'b0, freeze = 1'b0;
    logic        res_ready;
    logic [15:0] disp_word;
    logic [1:0]  disp_sel;
    logic        disp_blank, disp_nan, disp_inf;

    fpu_display_sequencer #(.DWELL_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .res(res),
        .res_valid(res_valid), .res_ready(res_ready), .mode_auto(mode_auto),
        .step_pulse(step_pulse), .freeze(freeze), .disp_word(disp_word),
        .disp_sel(disp_sel), .disp_blank(disp_blank), .disp_nan(disp_nan),
        .disp_inf(disp_inf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    // {word, sel, blank, nan, inf, ready}
    function automatic logic [21:0] pack(input logic [15:0] w, input logic [1:0] s,
                                         input logic b, input logic n, input logic i,
                                         input logic r);
        return {w, s, b, n, i, r};
    endfunction

    function automatic logic [21:0] cur();
        return pack(disp_word, disp_sel, disp_blank, disp_nan, disp_inf, res_ready);
    endfunction

    task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got word=%h sel=%0d blank=%b nan=%b inf=%b rdy=%b, want word=%h sel=%0d blank=%b nan=%b inf=%b rdy=%b",
                      nm, act[21:6], act[5:4], act[3], act[2], act[1], act[0],
                      exp[21:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    // ---------------- behavioural model ----------------
    // m_idx: 0 nothing shown, 1 A, 2 B, 3 result. m_cnt: cycles spent on the word.
    int          m_idx, m_cnt;
    logic [15:0] m_sh [1:3];
    logic        m_prev;

    always @(posedge clk or posedge rst) begin
        int idx, cnt;
        if (rst) begin
            m_idx  <= 0;
            m_cnt  <= 0;
            m_sh[1] <= '0; m_sh[2] <= '0; m_sh[3] <= '0;
            m_prev <= 1'b0;
        end else begin
            idx = m_idx;
            cnt = m_cnt;
            if (res_valid && !freeze) begin
                m_sh[1] <= op_a; m_sh[2] <= op_b; m_sh[3] <= res;
                idx = 3;
                cnt = 0;
            end else if (!freeze && idx != 0) begin
                if (mode_auto) begin
                    if (mode_auto != m_prev) cnt = 0;
                    else if (cnt == D - 1) begin
                        cnt = 0;
                        idx = (idx % 3) + 1;
                    end else cnt = cnt + 1;
                end else begin
                    cnt = 0;
                    if (step_pulse) idx = (idx % 3) + 1;
                end
            end
            m_idx  <= idx;
            m_cnt  <= cnt;
            m_prev <= mode_auto;
        end
    end

    function automatic logic [21:0] model_exp();
        logic [15:0] w;
        logic        special;
        w = (m_idx == 0) ? 16'h0000 : m_sh[m_idx];
        special = (((w >> 10) & 16'd31) == 16'd31);
        return pack(w, 2'(m_idx), m_idx == 0,
                    special && ((w % 1024) != 0), special && ((w % 1024) == 0),
                    !rst && !freeze);
    endfunction

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) chk("cycle", cur(), model_exp());
    end

    task automatic step_in();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] man_seq [3];

    initial begin
        // Reset and idle: step_pulse must do nothing.
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        step_in(); step_in();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_pulse = (i % 2 == 0);
            step_in();
        end
        step_pulse = 1'b0;
        chk("idle_blank", cur(), pack(16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));

        // Auto-mode capture and timed rotation.
        op_a = 16'h3C00; op_b = 16'h4000; res = 16'h4200;
        mode_auto = 1'b1; res_valid = 1'b1;
        step_in();
        res_valid = 1'b0;
        chk("cap_res", cur(), pack(16'h4200, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (3) step_in();
        chk("dwell_hold", cur(), pack(16'h4200, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
        step_in();
        chk("auto_a", cur(), pack(16'h3C00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (4) step_in();
        chk("auto_b", cur(), pack(16'h4000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (4) step_in();
        chk("auto_r", cur(), pack(16'h4200, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));

        // Manual stepping.
        mode_auto = 1'b0;
        step_in();
        man_seq[0] = 16'h3C00; man_seq[1] = 16'h4000; man_seq[2] = 16'h4200;
        for (int i = 0; i < 3; i++) begin
            step_pulse = 1'b1;
            step_in();
            step_pulse = 1'b0;
            chk("man_step", cur(), pack(man_seq[i], 2'(i + 1), 1'b0, 1'b0, 1'b0, 1'b1));
            step_in(); step_in();
            chk("man_hold", cur(), pack(man_seq[i], 2'(i + 1), 1'b0, 1'b0, 1'b0, 1'b1));
        end

        // Special values.
        op_a = 16'h0000; op_b = 16'h4000; res = 16'h7C00; res_valid = 1'b1;
        step_in();
        chk("inf_flag", cur(), pack(16'h7C00, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1));
        res = 16'h7E00;
        step_in();
        res_valid = 1'b0;
        chk("nan_flag", cur(), pack(16'h7E00, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1));
        step_pulse = 1'b1;
        step_in();
        step_pulse = 1'b0;
        chk("zero_flags", cur(), pack(16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));

        // Freeze while showing B, mid-dwell.
        op_a = 16'h3C00; op_b = 16'h4000; res = 16'h4200;
        mode_auto = 1'b1; res_valid = 1'b1;
        step_in();
        res_valid = 1'b0;
        repeat (8) step_in();
        chk("frz_pre_b", cur(), pack(16'h4000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (2) step_in();
        freeze = 1'b1; res_valid = 1'b1; res = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            step_in();
            chk("frz_hold", cur(), pack(16'h4000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        freeze = 1'b0; res_valid = 1'b0;
        step_in();
        chk("frz_resume", cur(), pack(16'h4000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        step_in();
        chk("frz_adv", cur(), pack(16'h4200, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));

        // Capture beats a same-edge step; async reset mid-dwell.
        mode_auto = 1'b0;
        step_in();
        step_pulse = 1'b1;
        step_in();
        chk("pri_at_a", cur(), pack(16'h3C00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
        res_valid = 1'b1; res = 16'h5555;
        step_in();
        step_pulse = 1'b0; res_valid = 1'b0;
        chk("cap_beats_step", cur(), pack(16'h5555, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
        mode_auto = 1'b1;
        step_in(); step_in();
        rst = 1'b1;
        #1;
        chk("async_rst", cur(), pack(16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        step_in(); step_in();
        rst = 1'b0;
        step_in();
        chk("post_rst", cur(), pack(16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            op_a       = 16'($urandom);
            op_b       = 16'($urandom);
            res        = ($urandom_range(0, 3) == 0) ? {1'b0, 5'h1F, 10'($urandom_range(0, 1) * $urandom)}
                                                      : 16'($urandom);
            res_valid  = ($urandom_range(0, 9) == 0);
            freeze     = ($urandom_range(0, 5) == 0);
            step_pulse = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) mode_auto = ~mode_auto;
            rst        = ($urandom_range(0, 299) == 0);
            step_in();
        end
        rst = 1'b0; res_valid = 1'b0; freeze = 1'b0; step_pulse = 1'b0;
        step_in();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
